fifo_rr_drain_arbiter: RTL and testbench
========================================

Name: fifo_rr_drain_arbiter

Overview:
- Drains N_CH upstream fifo_single_clock instances (SHOW_AHEAD "OFF", 1-cycle read latency) onto one shared valid/ready output stream.
- Round-robin grant with a per-grant burst limit.
- Issues req to at most one FIFO per cycle and never to an empty one, so FIFO underflow cannot occur.
- A 2-entry skid buffer absorbs read latency under downstream backpressure.

Parameters:
- N_CH, 4, number of upstream FIFOs (2..16)
- DW, 32, data width
- BURST, 8, max words per grant (>=1)
- CH_W, clogb2_f(N_CH), channel index width (localparam)

Ports:
- clk_i  in  1  clock
- arst_i  in  1  asynchronous active-high reset
- ch_empty_i  in  N_CH  empty_o of each FIFO
- ch_valid_i  in  N_CH  valid_o of each FIFO
- ch_data_i  in  N_CH*DW  data_o of each FIFO; channel k at [k*DW +: DW]
- ch_req_o  out  N_CH  req_i to each FIFO; one-hot or zero
- valid_o  out  1  output word valid
- data_o  out  DW  output word
- ch_id_o  out  CH_W  source channel of data_o
- ready_i  in  1  downstream accept; transfer when valid_o && ready_i
- busy_o  out  1  state != IDLE, or a word is in flight or buffered

Behaviour:
- Interface: one clock, clk_i; reset arst_i is asynchronous, active-high.
- Reset values: ch_req_o=0, valid_o=0, data_o=0, ch_id_o=0, busy_o=0, state=IDLE, rr_ptr=0, burst_cnt=0, inflight=0, skid empty.
- States: IDLE, ARB, BURST.
  - IDLE: go to ARB when any ch_empty_i bit is 0.
  - ARB (1 cycle, no req): grant = first non-empty channel scanning from rr_ptr upward with wrap mod N_CH; burst_cnt=0; go to BURST. If all channels are empty, go to IDLE.
  - BURST: ch_req_o[grant] = !ch_empty_i[grant] && credit_ok. This is combinational, so the empty update caused by a req at cycle t is honoured at t+1. Each req increments burst_cnt.
  - Leave BURST for ARB when burst_cnt reaches BURST, or when ch_empty_i[grant]=1 in a cycle with no req issued.
  - On leaving BURST: rr_ptr = grant+1, wrapping N_CH-1 -> 0.
- Credit: credit_ok = (skid_occ + inflight - pop) < 2, where pop = valid_o && ready_i. Sustains 1 word/cycle with ready_i held high.
- inflight: register, set the cycle after a req; inflight_ch holds the channel requested.
- Capture: when inflight && ch_valid_i[inflight_ch], push {inflight_ch, ch_data_i slice} into the skid buffer.
  - If inflight is 1 but ch_valid_i is 0, nothing is pushed. This indicates a FIFO protocol violation; flag it in simulation only.
- Skid buffer: 2 entries, FIFO order. valid_o = occupancy != 0; data_o/ch_id_o come from the head entry. Push and pop in the same cycle are both allowed. Data is never dropped, by the credit rule.
- Output latency: req at t -> word captured at t+1 -> valid_o at t+2 (registered skid output).
- Burst throughput with ready_i=1: BURST words in BURST cycles, plus 1 ARB cycle per grant.
- N_CH=1: grant is always 0; ARB still costs 1 cycle.
- Reset mid-operation clears in-flight and buffered words; those words are lost. Upstream FIFOs have their own synchronous resets, and the integrator resets both together.

Optional Feature:
- Macro FIFO_ARB_PRIO0_EN.
  - Defined: in ARB, channel 0 wins whenever ch_empty_i[0]=0, regardless of rr_ptr. rr_ptr is not updated after a channel-0 grant. Other channels take round-robin among themselves. Preemption happens only at burst boundaries.
  - Undefined: pure round-robin over all channels.

Decomposition:
- common_pkg: add typedef enum logic [1:0] {IDLE, ARB, BURST} arb_state_t; reuse clogb2_f.
- Sub-module fifo_skid2: 2-entry buffer with parameter W = DW+CH_W, push/pop, valid, occupancy output, async reset.

Test Plan:
- Reset: assert arst_i mid-burst with ch0 holding 5 words -> all outputs 0 in the same cycle; after release the state is IDLE and no req is issued while all channels are empty.
- Single channel, ready_i=1: ch2 holds 3 words A,B,C -> ARB, then req on 3 consecutive cycles; valid_o for 3 cycles with A,B,C and ch_id_o=2; returns to IDLE.
- Round-robin, BURST=8: ch0=20 words, ch1=20 words, ch3=2 words.
  - Grant order ch0(8), ch1(8), ch3(2), ch0(8), ch1(8), ch0(4), ch1(4).
  - 1 idle ARB cycle between bursts.
- Backpressure: ready_i=0 for 5 cycles during ch1 burst -> at most 2 reqs are issued, then ch_req_o=0. No word is lost or duplicated; order is preserved on release.
- Empty boundary: FIFO count=1 -> exactly one req; ch_req_o never asserted while ch_empty_i=1; FIFO underflow_o stays 0.
- FIFO_ARB_PRIO0_EN: ch0 refilled during ch1 burst -> ch0 granted at the next ARB ahead of ch2; without the macro, ch2 is granted first.

Source files
------------

// File: rtl/fifo_rr_drain_arbiter_pkg.sv
// Shared FSM state type and width helper for fifo_rr_drain_arbiter.
package fifo_rr_drain_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, ARB, BURST} arb_state_t;

  // Bits needed to index 'value' items; never returns less than 1.
  function automatic int clogb2_f(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/fifo_skid2.sv
// Two-entry FIFO-order skid buffer with a registered head entry; push and pop may coincide.
module fifo_skid2 #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         arst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic         valid_o,
  output logic [W-1:0] dout_o,
  output logic [1:0]   occ_o
);

  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic [1:0]   occ_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (occ_q == 2'd0) head_q <= din_i;
          else               tail_q <= din_i;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          occ_q  <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            head_q <= din_i;
          end else begin
            head_q <= tail_q;
            tail_q <= din_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid_o = (occ_q != 2'd0);
  assign dout_o  = head_q;
  assign occ_o   = occ_q;

endmodule

// File: rtl/fifo_rr_drain_arbiter.sv
// Round-robin drain of N_CH show-ahead-off FIFOs onto one valid/ready stream with per-grant burst limit.
// Optional FIFO_ARB_PRIO0_EN: channel 0 wins every arbitration in which it is non-empty.
module fifo_rr_drain_arbiter
  import fifo_rr_drain_arbiter_pkg::*;
#(
  parameter int  N_CH  = 4,
  parameter int  DW    = 32,
  parameter int  BURST = 8,
  localparam int CH_W  = clogb2_f(N_CH)
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  input  logic [N_CH-1:0]      ch_empty_i,
  input  logic [N_CH-1:0]      ch_valid_i,
  input  logic [N_CH*DW-1:0]   ch_data_i,
  output logic [N_CH-1:0]      ch_req_o,
  output logic                 valid_o,
  output logic [DW-1:0]        data_o,
  output logic [CH_W-1:0]      ch_id_o,
  input  logic                 ready_i,
  output logic                 busy_o
);

  localparam int BC_W = clogb2_f(BURST + 1);
  localparam int SW   = DW + CH_W;

  arb_state_t      state_q;
  logic [CH_W-1:0] rr_ptr_q;
  logic [CH_W-1:0] grant_q;
  logic [CH_W-1:0] inflight_ch_q;
  logic [BC_W-1:0] burst_cnt_q;
  logic            inflight_q;

  logic [CH_W-1:0] rr_ptr_d;
  logic [CH_W-1:0] arb_grant;
  logic [CH_W-1:0] scan_idx;
  logic            arb_found;
  logic            req_any;
  logic            pop;
  logic            push;
  logic            credit_ok;
  logic [2:0]      credit_cnt;
  logic [1:0]      skid_occ;
  logic [SW-1:0]   skid_din;
  logic [SW-1:0]   skid_dout;

  always_comb begin
    arb_grant = '0;
    arb_found = 1'b0;
    scan_idx  = '0;
`ifdef FIFO_ARB_PRIO0_EN
    if (!ch_empty_i[0]) arb_found = 1'b1;
`endif
    for (int i = 0; i < N_CH; i++) begin
      scan_idx = CH_W'((int'(rr_ptr_q) + i) % N_CH);
      if (!arb_found && !ch_empty_i[scan_idx]) begin
        arb_found = 1'b1;
        arb_grant = scan_idx;
      end
    end
  end

  // Words already owed to the skid (buffered or in flight) must never exceed its two slots.
  assign pop        = valid_o & ready_i;
  assign credit_cnt = {1'b0, skid_occ} + {2'b00, inflight_q} - {2'b00, pop};
  assign credit_ok  = (credit_cnt < 3'd2);

  always_comb begin
    ch_req_o = '0;
    if (state_q == fifo_rr_drain_arbiter_pkg::BURST && !ch_empty_i[grant_q] && credit_ok)
      ch_req_o[grant_q] = 1'b1;
  end

  assign req_any  = |ch_req_o;
  assign rr_ptr_d = (grant_q == CH_W'(N_CH - 1)) ? '0 : grant_q + 1'b1;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      grant_q       <= '0;
      burst_cnt_q   <= '0;
      inflight_q    <= 1'b0;
      inflight_ch_q <= '0;
    end else begin
      inflight_q <= req_any;
      if (req_any) inflight_ch_q <= grant_q;
      case (state_q)
        IDLE: if (~&ch_empty_i) state_q <= ARB;
        ARB: begin
          if (arb_found) begin
            grant_q     <= arb_grant;
            burst_cnt_q <= '0;
            state_q     <= fifo_rr_drain_arbiter_pkg::BURST;
          end else begin
            state_q <= IDLE;
          end
        end
        fifo_rr_drain_arbiter_pkg::BURST: begin
          if (req_any) burst_cnt_q <= burst_cnt_q + 1'b1;
          if ((req_any && burst_cnt_q == BC_W'(BURST - 1)) || (!req_any && ch_empty_i[grant_q])) begin
            state_q <= ARB;
`ifdef FIFO_ARB_PRIO0_EN
            if (grant_q != '0) rr_ptr_q <= rr_ptr_d;
`else
            rr_ptr_q <= rr_ptr_d;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign push     = inflight_q & ch_valid_i[inflight_ch_q];
  assign skid_din = {inflight_ch_q, ch_data_i[inflight_ch_q*DW +: DW]};

  fifo_skid2 #(.W(SW)) u_skid (
    .clk_i   (clk_i),
    .arst_i  (arst_i),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (skid_din),
    .valid_o (valid_o),
    .dout_o  (skid_dout),
    .occ_o   (skid_occ)
  );

  assign {ch_id_o, data_o} = skid_dout;
  assign busy_o = (state_q != IDLE) | inflight_q | (skid_occ != 2'd0);

`ifndef SYNTHESIS
  // A read request must be answered by valid_o one cycle later; anything else is an upstream fault.
  a_fifo_valid: assert property (@(posedge clk_i) disable iff (arst_i)
    inflight_q |-> ch_valid_i[inflight_ch_q]);
`endif

endmodule

// File: tb/tb_fifo_rr_drain_arbiter.sv
// Bench for fifo_rr_drain_arbiter: behavioural upstream FIFOs, scoreboard queue, negedge output monitor.
module tb_fifo_rr_drain_arbiter;

  localparam int N_CH  = 4;
  localparam int DW    = 32;
  localparam int BURST = 8;
  localparam int CH_W  = 2;

  logic                clk_i = 1'b0;
  logic                arst_i;
  logic [N_CH-1:0]     ch_empty_i;
  logic [N_CH-1:0]     ch_valid_i;
  logic [N_CH*DW-1:0]  ch_data_i;
  logic [N_CH-1:0]     ch_req_o;
  logic                valid_o;
  logic [DW-1:0]       data_o;
  logic [CH_W-1:0]     ch_id_o;
  logic                ready_i;
  logic                busy_o;

  fifo_rr_drain_arbiter #(.N_CH(N_CH), .DW(DW), .BURST(BURST)) dut (
    .clk_i      (clk_i),
    .arst_i     (arst_i),
    .ch_empty_i (ch_empty_i),
    .ch_valid_i (ch_valid_i),
    .ch_data_i  (ch_data_i),
    .ch_req_o   (ch_req_o),
    .valid_o    (valid_o),
    .data_o     (data_o),
    .ch_id_o    (ch_id_o),
    .ready_i    (ready_i),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int uf      = 0;
  int onehot_err = 0;

  logic [DW-1:0]      fq [N_CH][$];
  logic [CH_W+DW-1:0] exp_q [$];
  int req_log [$];
  int req_cyc [$];
  int exp_rc [$];
  int exp_rl [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] wd(input int ch, input int i);
    return 32'hA000_0000 + DW'(ch * 4096 + i);
  endfunction

  task automatic load(input int ch, input int first, input int n);
    for (int i = 0; i < n; i++) fq[ch].push_back(wd(ch, first + i));
    if (n > 0) ch_empty_i[ch] = 1'b0;
  endtask

  task automatic expect_run(input int ch, input int first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({CH_W'(ch), wd(ch, first + i)});
  endtask

  // One clock of the upstream FIFO model: reqs sampled mid-cycle, pops land just after the edge.
  task automatic step();
    logic [N_CH-1:0] r;
    @(negedge clk_i);
    r = ch_req_o;
    if (r != '0 && $countones(r) != 1) onehot_err++;
    for (int k = 0; k < N_CH; k++)
      if (r[k]) begin
        req_log.push_back(k);
        req_cyc.push_back(cyc);
      end
    @(posedge clk_i);
    #1;
    cyc++;
    for (int k = 0; k < N_CH; k++) begin
      ch_valid_i[k] = 1'b0;
      if (r[k]) begin
        if (fq[k].size() > 0) begin
          ch_data_i[k*DW +: DW] = fq[k].pop_front();
          ch_valid_i[k] = 1'b1;
        end else begin
          uf++;
        end
      end
      ch_empty_i[k] = (fq[k].size() == 0);
    end
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy_o) && n < 400) begin
      step();
      n++;
    end
    chk({nm, "_sb_empty"}, exp_q.size(), 0);
    chk({nm, "_idle"}, busy_o, 0);
  endtask

  task automatic check_runs(input string nm);
    int rc [$];
    int rl [$];
    for (int i = 0; i < req_log.size(); i++) begin
      if (i == 0 || req_log[i] != req_log[i-1]) begin
        rc.push_back(req_log[i]);
        rl.push_back(1);
      end else begin
        rl[rl.size()-1]++;
      end
    end
    chk({nm, "_nruns"}, rc.size(), exp_rc.size());
    for (int i = 0; i < exp_rc.size() && i < rc.size(); i++) begin
      chk($sformatf("%s_run%0d_ch", nm, i), rc[i], exp_rc[i]);
      chk($sformatf("%s_run%0d_len", nm, i), rl[i], exp_rl[i]);
    end
  endtask

  // Monitor: every accepted output word is popped from the scoreboard and compared.
  initial begin
    logic [CH_W+DW-1:0] e;
    forever begin
      @(negedge clk_i);
      if (!arst_i && valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_extra: got ch=%0d data=%0h expected no word", ch_id_o, data_o);
        end else begin
          e = exp_q.pop_front();
          chk("sb_word", {ch_id_o, data_o}, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int l0;
    int n0;
    int bad;
    int gaps [$];
    int exp_gap [6];

    arst_i = 1'b1; ready_i = 1'b1;
    ch_empty_i = '1; ch_valid_i = '0; ch_data_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_req", ch_req_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_id", ch_id_o, 0);
    chk("rst_busy", busy_o, 0);
    #2 arst_i = 1'b0;
    repeat (2) step();

    // Single channel: ch2 holds three words.
    req_log.delete(); req_cyc.delete(); uf = 0;
    l0 = cyc;
    load(2, 0, 3); expect_run(2, 0, 3);
    repeat (3) step();
    chk("a_valid_t3", valid_o, 0);
    step();
    chk("a_valid_t4", valid_o, 1);
    drain("a");
    chk("a_nreq", req_log.size(), 3);
    if (req_cyc.size() >= 3) begin
      chk("a_req_first", req_cyc[0], l0 + 2);
      chk("a_req_last", req_cyc[2], l0 + 4);
    end
    chk("a_uf", uf, 0);

    // Reset in the middle of a ch0 burst; buffered words are discarded.
    load(0, 0, 5);
    repeat (3) step();
    chk("rst_pre_busy", busy_o, 1);
    chk("rst_pre_req", ch_req_o, 4'b0001);
    #2 arst_i = 1'b1;
    #1;
    chk("rst_mid_req", ch_req_o, 0);
    chk("rst_mid_valid", valid_o, 0);
    chk("rst_mid_data", data_o, 0);
    chk("rst_mid_id", ch_id_o, 0);
    chk("rst_mid_busy", busy_o, 0);
    for (int k = 0; k < N_CH; k++) fq[k].delete();
    ch_empty_i = '1; ch_valid_i = '0;
    @(posedge clk_i);
    #2 arst_i = 1'b0;
    n0 = req_log.size();
    repeat (6) step();
    chk("rst_idle_req", req_log.size(), n0);
    chk("rst_idle_busy", busy_o, 0);

    // Round robin with burst limit.
    req_log.delete(); req_cyc.delete(); uf = 0;
    load(0, 0, 20); load(1, 0, 20); load(3, 0, 2);
    expect_run(0, 0, 8); expect_run(1, 0, 8); expect_run(3, 0, 2); expect_run(0, 8, 8);
    expect_run(1, 8, 8); expect_run(0, 16, 4); expect_run(1, 16, 4);
    drain("rr");
    exp_rc = '{0, 1, 3, 0, 1, 0, 1};
    exp_rl = '{8, 8, 2, 8, 8, 4, 4};
    check_runs("rr");
    bad = 0;
    gaps.delete();
    for (int i = 1; i < req_log.size(); i++) begin
      if (req_log[i] == req_log[i-1]) begin
        if (req_cyc[i] - req_cyc[i-1] != 1) bad++;
      end else begin
        gaps.push_back(req_cyc[i] - req_cyc[i-1]);
      end
    end
    chk("rr_contig", bad, 0);
    exp_gap = '{2, 2, 3, 2, 2, 3};
    chk("rr_ngaps", gaps.size(), 6);
    for (int i = 0; i < 6 && i < gaps.size(); i++) chk($sformatf("rr_gap%0d", i), gaps[i], exp_gap[i]);
    chk("rr_uf", uf, 0);

    // Backpressure during a ch1 burst.
    req_log.delete(); req_cyc.delete(); uf = 0;
    load(1, 100, 12); expect_run(1, 100, 12);
    repeat (4) step();
    ready_i = 1'b0;
    n0 = req_log.size();
    repeat (5) step();
    chk("bp_win_reqs_le2", (req_log.size() - n0) <= 2, 1);
    chk("bp_req_stalled", ch_req_o, 0);
    chk("bp_valid_held", valid_o, 1);
    ready_i = 1'b1;
    drain("bp");
    chk("bp_nreq", req_log.size(), 12);
    chk("bp_uf", uf, 0);

    // Single-word FIFO.
    req_log.delete(); req_cyc.delete(); uf = 0;
    load(3, 0, 1); expect_run(3, 0, 1);
    drain("eb");
    chk("eb_nreq", req_log.size(), 1);
    chk("eb_uf", uf, 0);

    // ch0 refilled mid-burst of ch1 while ch2 waits.
    #2 arst_i = 1'b1;
    @(posedge clk_i);
    #2 arst_i = 1'b0;
    req_log.delete(); req_cyc.delete(); uf = 0;
    load(1, 0, 8); load(2, 0, 3);
`ifdef FIFO_ARB_PRIO0_EN
    expect_run(1, 0, 8); expect_run(0, 0, 2); expect_run(2, 0, 3);
    exp_rc = '{1, 0, 2};
    exp_rl = '{8, 2, 3};
`else
    expect_run(1, 0, 8); expect_run(2, 0, 3); expect_run(0, 0, 2);
    exp_rc = '{1, 2, 0};
    exp_rl = '{8, 3, 2};
`endif
    repeat (4) step();
    load(0, 0, 2);
    drain("pr");
    check_runs("pr");
    chk("pr_uf", uf, 0);

    chk("req_onehot", onehot_err, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
